booth_pp_accum: RTL and testbench

- Sequential radix-4 Booth decoder/accumulator: the consumer of the per-digit control vectors (set0/inv/X2) produced by the Booth encoder.
- Takes a 32-bit signed multiplicand B and the 16 digit controls for multiplier A, decodes each digit to a partial product in {0, ±B, ±2B}, shifts it by 2j and accumulates it into a 64-bit signed product.
- Sits between the encoder and the result writeback, with valid/ready on both sides.

---
 rtl/booth_pp_accum_if.sv | 24 ++
 rtl/booth_pp_accum.sv | 123 ++++++++++++
 tb/tb_booth_pp_accum.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/booth_pp_accum_if.sv
// Operand/control bundle and product handshake for the radix-4 Booth accumulator.
// The encoder/writeback side uses master; the accumulator uses slave.
interface booth_pp_accum_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] B;
    logic [15:0] set0;
    logic [15:0] inv;
    logic [15:0] X2;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] P;
    logic        ctrl_err;

    modport master (
        output in_valid, B, set0, inv, X2, out_ready,
        input  in_ready, out_valid, P, ctrl_err
    );

    modport slave (
        input  in_valid, B, set0, inv, X2, out_ready,
        output in_ready, out_valid, P, ctrl_err
    );
endinterface

// File: rtl/booth_pp_accum.sv
// Sequential radix-4 Booth decoder/accumulator: decodes DPC digit controls per cycle
// into partial products {0, +-B, +-2B}, shifts by 2j and sums into a 64-bit product.
module booth_pp_accum #(
    parameter int unsigned DPC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    booth_pp_accum_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] K_STEP = 4'(DPC);
    localparam logic [3:0] K_LAST = 4'(16 - DPC);

    state_t      state_q, state_d;
    logic [63:0] b_q, b_d;
    logic [15:0] set0_q, set0_d;
    logic [15:0] inv_q, inv_d;
    logic [15:0] x2_q, x2_d;
    logic [63:0] acc_q, acc_d;
    logic [3:0]  k_q, k_d;
    logic        err_q, err_d;

    logic [63:0] acc_sum;
    logic        err_sum;

    // Decode and accumulate digits k..k+DPC-1; set0 wins over inv/X2.
    always_comb begin : digit_sum
        logic [63:0] mag;
        logic [63:0] pp;
        logic [3:0]  j;
        acc_sum = acc_q;
        err_sum = err_q;
        mag     = '0;
        pp      = '0;
        j       = '0;
        for (int unsigned i = 0; i < DPC; i++) begin
            j   = k_q + 4'(i);
            mag = x2_q[j] ? (b_q << 1) : b_q;
            if (set0_q[j]) begin
                pp = '0;
            end else begin
                pp = inv_q[j] ? (~mag + 64'd1) : mag;
            end
            acc_sum = acc_sum + (pp << {j, 1'b0});
            if (set0_q[j] && (inv_q[j] || x2_q[j])) begin
                err_sum = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        set0_d  = set0_q;
        inv_d   = inv_q;
        x2_d    = x2_q;
        acc_d   = acc_q;
        k_d     = k_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    b_d     = {{32{bus.B[31]}}, bus.B};
                    set0_d  = bus.set0;
                    inv_d   = bus.inv;
                    x2_d    = bus.X2;
                    acc_d   = '0;
                    k_d     = '0;
                    err_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_sum;
                err_d = err_sum;
                k_d   = k_q + K_STEP;
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            b_q     <= '0;
            set0_q  <= '0;
            inv_q   <= '0;
            x2_q    <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            set0_q  <= set0_d;
            inv_q   <= inv_d;
            x2_q    <= x2_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.P         = (state_q == DONE) ? acc_q : '0;
    assign bus.ctrl_err  = (state_q == DONE) ? err_q : 1'b0;

endmodule

// File: tb/tb_booth_pp_accum.sv
// Drives identical bundles into a DPC=1 and a DPC=4 accumulator and checks products
// against signed multiplication and a digit-value model.
module tb_booth_pp_accum;

    logic clk;
    logic rst_n;

    booth_pp_accum_if if1 ();
    booth_pp_accum_if if4 ();

    booth_pp_accum #(.DPC(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    booth_pp_accum #(.DPC(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, got, exp);
        end
    endtask

    // Radix-4 Booth recoding of A: digit j from bits (2j+1, 2j, 2j-1).
    function automatic void encode(input logic [31:0] a, output logic [15:0] s0,
                                   output logic [15:0] iv, output logic [15:0] x2);
        logic [32:0] ax;
        int d;
        ax = {a, 1'b0};
        for (int j = 0; j < 16; j++) begin
            d = -2 * int'(ax[2*j+2]) + int'(ax[2*j+1]) + int'(ax[2*j]);
            s0[j] = (d == 0);
            iv[j] = (d < 0);
            x2[j] = (d == 2) || (d == -2);
        end
    endfunction

    // Independent digit-value model for arbitrary (possibly illegal) controls.
    function automatic longint digit_model(input logic [31:0] b, input logic [15:0] s0,
                                           input logic [15:0] iv, input logic [15:0] x2);
        longint sum;
        longint v;
        sum = 0;
        for (int j = 0; j < 16; j++) begin
            if (s0[j]) v = 0;
            else v = (iv[j] ? -1 : 1) * (x2[j] ? 2 : 1);
            sum += v * longint'($signed(b)) * (longint'(1) << (2*j));
        end
        return sum;
    endfunction

    function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
        return 64'(longint'($signed(a)) * longint'($signed(b)));
    endfunction

    task automatic drive(input logic v, input logic [31:0] b, input logic [15:0] s0,
                         input logic [15:0] iv, input logic [15:0] x2);
        if1.in_valid = v; if4.in_valid = v;
        if1.B = b;        if4.B = b;
        if1.set0 = s0;    if4.set0 = s0;
        if1.inv = iv;     if4.inv = iv;
        if1.X2 = x2;      if4.X2 = x2;
    endtask

    // Called at a negedge with both DUTs idle; returns at the negedge after capture
    // with the inputs scrambled so later changes are proven irrelevant.
    task automatic start_raw(input logic [31:0] b, input logic [15:0] s0,
                             input logic [15:0] iv, input logic [15:0] x2);
        drive(1'b1, b, s0, iv, x2);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, $urandom, 16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        logic [15:0] s0, iv, x2;
        encode(a, s0, iv, x2);
        start_raw(b, s0, iv, x2);
    endtask

    // Waits for both products (out_ready assumed high), checks value, error flag, latency.
    task automatic finish_txn(input string tag, input logic [63:0] exp_p, input logic exp_err);
        int n;
        bit seen1, seen4;
        n = 0; seen1 = 0; seen4 = 0;
        while (!(seen1 && seen4) && n < 60) begin
            n++;
            if (!seen1 && if1.out_valid) begin
                seen1 = 1;
                check({tag, "_p1"}, if1.P, exp_p);
                check({tag, "_err1"}, 64'(if1.ctrl_err), 64'(exp_err));
                check({tag, "_lat1"}, 64'(n), 64'd17);
            end
            if (!seen4 && if4.out_valid) begin
                seen4 = 1;
                check({tag, "_p4"}, if4.P, exp_p);
                check({tag, "_err4"}, 64'(if4.ctrl_err), 64'(exp_err));
                check({tag, "_lat4"}, 64'(n), 64'd5);
            end
            @(negedge clk);
        end
        if (!(seen1 && seen4)) check({tag, "_timeout"}, 64'({seen1, seen4}), 64'd3);
    endtask

    initial begin
        logic [31:0] a, b;
        int n;

        rst_n = 1'b0;
        if1.out_ready = 1'b1; if4.out_ready = 1'b1;
        drive(1'b0, '0, '0, '0, '0);
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'({if1.in_ready, if4.in_ready}), 64'd3);
        check("rst_out_valid", 64'({if1.out_valid, if4.out_valid}), 64'd0);
        check("rst_p", if1.P | if4.P, 64'd0);
        check("rst_err", 64'({if1.ctrl_err, if4.ctrl_err}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        start(32'd3, 32'd5);
        finish_txn("a3b5", 64'h0000_0000_0000_000F, 1'b0);

        start(32'hFFFF_FFFF, 32'd7);
        finish_txn("neg1x7", 64'hFFFF_FFFF_FFFF_FFF9, 1'b0);

        start(32'h8000_0000, 32'h8000_0000);
        finish_txn("minxmin", 64'h4000_0000_0000_0000, 1'b0);

        // Backpressure in DONE, then accept with a new bundle already offered.
        if1.out_ready = 1'b0; if4.out_ready = 1'b0;
        start(32'd1000, 32'hFFFF_FFFE);
        n = 0;
        while (!if1.out_valid && n < 40) begin n++; @(negedge clk); end
        check("bp_reach_done", 64'({if1.out_valid, if4.out_valid}), 64'd3);
        for (int c = 0; c < 5; c++) begin
            check("bp_p1_hold", if1.P, 64'hFFFF_FFFF_FFFF_F830);
            check("bp_p4_hold", if4.P, 64'hFFFF_FFFF_FFFF_F830);
            check("bp_in_ready", 64'({if1.in_ready, if4.in_ready}), 64'd0);
            @(negedge clk);
        end
        if1.out_ready = 1'b1; if4.out_ready = 1'b1;
        encode(32'hFFFF_FFFB, if1.set0, if1.inv, if1.X2);
        encode(32'hFFFF_FFFB, if4.set0, if4.inv, if4.X2);
        if1.B = 32'd9; if4.B = 32'd9;
        if1.in_valid = 1'b1; if4.in_valid = 1'b1;
        @(negedge clk);
        check("accept_idle", 64'({if1.in_ready, if4.in_ready}), 64'd3);
        check("accept_noval", 64'({if1.out_valid, if4.out_valid}), 64'd0);
        start(32'hFFFF_FFFB, 32'd9);
        finish_txn("m5x9", 64'hFFFF_FFFF_FFFF_FFD3, 1'b0);

        // Synchronous reset in the middle of a DPC=1 run.
        start(32'h1234_5678, 32'h0BAD_F00D);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_in_ready", 64'(if1.in_ready), 64'd1);
        check("midrst_out", {if1.P[62:0], if1.out_valid}, 64'd0);
        check("midrst_err", 64'(if1.ctrl_err), 64'd0);
        n = 0;
        for (int c = 0; c < 25; c++) begin
            if (if1.out_valid || if4.out_valid) n++;
            @(negedge clk);
        end
        check("midrst_no_valid", 64'(n), 64'd0);
        start(32'd2, 32'd2);
        finish_txn("a2b2", 64'd4, 1'b0);

        // Illegal control on digit 0 (set0 with X2), all other digits zero.
        start_raw(32'd123, 16'hFFFF, 16'h0000, 16'h0001);
        finish_txn("illegal", 64'd0, 1'b1);
        start(32'd11, 32'd123);
        finish_txn("legal_after", 64'd1353, 1'b0);

        // Random controls (including illegal combinations) against the digit model.
        for (int t = 0; t < 40; t++) begin
            logic [15:0] s0, iv, x2;
            b  = $urandom;
            s0 = 16'($urandom) & 16'($urandom);
            iv = 16'($urandom);
            x2 = 16'($urandom);
            start_raw(b, s0, iv, x2);
            finish_txn("rnd_ctrl", 64'(digit_model(b, s0, iv, x2)), |(s0 & (iv | x2)));
        end

        // Random signed operand sweep against plain multiplication.
        for (int t = 0; t < 1500; t++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 15))
                0: a = 32'h8000_0000;
                1: b = 32'h8000_0000;
                2: a = 32'h7FFF_FFFF;
                3: b = 32'hFFFF_FFFF;
                4: a = '0;
                default: ;
            endcase
            start(a, b);
            finish_txn("rnd", mul_ref(a, b), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
